rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Four-requester round-robin arbiter that shares one decoded resource (one of four select lines) between requesters.
- Outputs a registered one-hot grant plus its 2-bit encoded select (grant == 1 << grant_sel), so the 2-to-4 decoder path downstream is driven from a single owner.
- Supports owner-initiated release, request withdrawal, and a hold-time limit that forces preemption so no requester starves the others.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; 0 disables the limit.
- CNT_W, 8, hold counter width; MAX_HOLD must be <= 2**CNT_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases at this edge; ignored when grant_valid = 0.
- grant  output  4  registered one-hot grant; all-zero when idle.
- grant_sel  output  2  encoded index of the owner; holds the last owner when idle.
- grant_valid  output  1  high while any grant bit is high.
- timeout  output  1  one-cycle pulse on the edge where a forced release occurs.

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (rst_n low, asynchronous, at any time, including mid-grant): grant = 4'b0000, grant_sel = 2'd0, grant_valid = 0, timeout = 0, state = IDLE, priority pointer ptr = 0, hold_cnt = 0. Outputs are valid from the first edge after rst_n rises.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - If req != 0 at an edge, grant the first set bit scanning ptr, ptr+1, ... (mod 4).
  - On that edge: grant/grant_sel/grant_valid update, hold_cnt = 0, go to GRANT.
  - Latency from req sampled to grant visible: 1 cycle.
- GRANT (owner k = grant_sel): release at an edge when any of the following holds:
  - (a) done = 1;
  - (b) req[k] = 0;
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
  - On release: grant = 0, grant_valid = 0, ptr = k+1 (mod 4; 3 wraps to 0), go to IDLE.
  - timeout = 1 for that one cycle only if (c) is true and neither (a) nor (b) is.
  - Otherwise hold_cnt increments by 1 each edge.
- Release always inserts exactly one idle cycle (grant = 0) before the next grant. There is no back-to-back ownership change.
- Simultaneous events:
  - A new req bit rising during GRANT has no effect until IDLE.
  - done together with req[k] dropping is a single normal release; timeout = 0.
  - If the released owner still requests and is the only requester, it is re-granted after the idle cycle; the pointer rotation does not block a lone requester.
- hold_cnt never wraps, because release occurs at MAX_HOLD-1. With MAX_HOLD = 0 the counter saturates at 2**CNT_W - 1.
- grant is always one-hot or zero. grant_valid == |grant.

Test Plan:
- Reset then req = 4'b1010 held → grant 4'b0010, sel 1, at edge 1; done at edge 3 → grant 0 at edge 4; grant 4'b1000, sel 3, at edge 5.
- req = 4'b1111 held, done pulsed each grant cycle → grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one zero cycle (pointer wrap 3→0).
- MAX_HOLD = 4, req = 4'b0100 held, no done → grant 0100 for exactly 4 cycles; timeout = 1 on the release edge; 1 idle cycle; re-granted 0100.
- Owner 2 granted, req[2] dropped with req = 4'b0001 → release next edge with timeout = 0; then grant 0001.
- rst_n pulled low mid-grant (grant 1000, hold_cnt 5) asynchronously → grant = 0, grant_valid = 0 immediately without a clock; after release, req = 4'b1111 → grant 0001 (ptr reset to 0).
- MAX_HOLD = 0, req = 4'b0001 held for 300 cycles → grant stays 0001, timeout never asserts.

Source files
------------

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin decode arbiter.
// The master side drives requests and release; the slave (arbiter) drives the grant.
interface rr_decode_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_sel;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_sel,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_sel,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter owning one decoded select line at a time.
// Owners release on done, on request withdrawal, or when the hold limit forces preemption.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_decode_arbiter_if.slave    arb
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // First requester at or after the pointer, wrapping modulo four.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = ptr_v;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_v + 2'(i);
      if (!found && req_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       grant_r, grant_s;
  logic [1:0]       sel_r, sel_s;
  logic             valid_r, valid_s;
  logic             timeout_r, timeout_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [1:0]       pick_s;
  logic             rel_done_s, rel_drop_s, rel_hold_s;

  // Next-state and next-output computation for the IDLE/GRANT controller.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    sel_s      = sel_r;
    valid_s    = valid_r;
    timeout_s  = 1'b0;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    pick_s     = rr_pick(arb.req, ptr_r);
    rel_done_s = 1'b0;
    rel_drop_s = 1'b0;
    rel_hold_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (arb.req != 4'b0000) begin
          sel_s      = pick_s;
          grant_s    = 4'b0001 << pick_s;
          valid_s    = 1'b1;
          hold_cnt_s = {CNT_W{1'b0}};
          state_s    = GRANT;
        end else begin
          state_s    = IDLE;
        end
      end
      GRANT: begin
        rel_done_s = arb.done;
        rel_drop_s = ~arb.req[sel_r];
        rel_hold_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);
        if (rel_done_s || rel_drop_s || rel_hold_s) begin
          grant_s   = 4'b0000;
          valid_s   = 1'b0;
          ptr_s     = sel_r + 2'd1;
          state_s   = IDLE;
          // Only a pure hold-limit release is flagged; owner-driven releases are normal.
          timeout_s = rel_hold_s & ~rel_done_s & ~rel_drop_s;
        end else if (hold_cnt_r != CNT_MAX) begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 4'b0000;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_r    <= 4'b0000;
      sel_r      <= 2'd0;
      valid_r    <= 1'b0;
      timeout_r  <= 1'b0;
      ptr_r      <= 2'd0;
      hold_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      sel_r      <= sel_s;
      valid_r    <= valid_s;
      timeout_r  <= timeout_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  assign arb.grant       = grant_r;
  assign arb.grant_sel   = sel_r;
  assign arb.grant_valid = valid_r;
  assign arb.timeout     = timeout_r;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench: three arbiters (hold limit 16, 4, disabled) share one stimulus stream;
// a behavioural model pushes expected outputs per edge, compared one cycle later.
module tb_rr_decode_arbiter;

  logic clk;
  logic rst_n;

  rr_decode_arbiter_if b16 ();
  rr_decode_arbiter_if b4 ();
  rr_decode_arbiter_if b0 ();

  rr_decode_arbiter #(.MAX_HOLD(16), .CNT_W(8)) u_h16 (.clk(clk), .rst_n(rst_n), .arb(b16));
  rr_decode_arbiter #(.MAX_HOLD(4),  .CNT_W(8)) u_h4  (.clk(clk), .rst_n(rst_n), .arb(b4));
  rr_decode_arbiter #(.MAX_HOLD(0),  .CNT_W(8)) u_h0  (.clk(clk), .rst_n(rst_n), .arb(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int mh[3] = '{16, 4, 0};
  int m_owner[3];
  int m_ptr[3];
  int m_cnt[3];
  bit m_busy[3];
  bit m_to[3];

  logic [23:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (grant,sel,valid,timeout)", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = 0;
      m_ptr[i]   = 0;
      m_cnt[i]   = 0;
      m_busy[i]  = 1'b0;
      m_to[i]    = 1'b0;
    end
  endtask

  // Advance one instance by one clock edge and return its expected output word.
  task automatic model_step(input int i, input logic [3:0] r, input logic d, output logic [7:0] e);
    bit a, b, c;
    logic [3:0] g;
    if (!m_busy[i]) begin
      m_to[i] = 1'b0;
      for (int off = 0; off < 4; off++) begin
        if (!m_busy[i] && r[(m_ptr[i] + off) % 4]) begin
          m_owner[i] = (m_ptr[i] + off) % 4;
          m_busy[i]  = 1'b1;
          m_cnt[i]   = 0;
        end
      end
    end else begin
      a = d;
      b = !r[m_owner[i]];
      c = (mh[i] != 0) && (m_cnt[i] == mh[i] - 1);
      if (a || b || c) begin
        m_busy[i] = 1'b0;
        m_ptr[i]  = (m_owner[i] + 1) % 4;
        m_to[i]   = c && !a && !b;
      end else begin
        if (m_cnt[i] < 255) m_cnt[i]++;
        m_to[i] = 1'b0;
      end
    end
    g = m_busy[i] ? (4'b0001 << m_owner[i]) : 4'b0000;
    e = {g, 2'(m_owner[i]), m_busy[i], m_to[i]};
  endtask

  task automatic drive_and_predict(input logic [3:0] r, input logic d);
    logic [7:0] e0, e1, e2;
    b16.req = r; b16.done = d;
    b4.req  = r; b4.done  = d;
    b0.req  = r; b0.done  = d;
    model_step(0, r, d, e0);
    model_step(1, r, d, e1);
    model_step(2, r, d, e2);
    sb_q.push_back({e2, e1, e0});
  endtask

  // At each falling edge: retire the previous edge's prediction, then drive the next inputs.
  task automatic cycle(input logic [3:0] r, input logic d);
    logic [23:0] e;
    @(negedge clk);
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq($sformatf("h16 c%0d", cyc), {b16.grant, b16.grant_sel, b16.grant_valid, b16.timeout}, e[7:0]);
      check_eq($sformatf("h4 c%0d", cyc),  {b4.grant,  b4.grant_sel,  b4.grant_valid,  b4.timeout},  e[15:8]);
      check_eq($sformatf("h0 c%0d", cyc),  {b0.grant,  b0.grant_sel,  b0.grant_valid,  b0.timeout},  e[23:16]);
    end
    drive_and_predict(r, d);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst h16", {b16.grant, b16.grant_sel, b16.grant_valid, b16.timeout}, 8'b0000_00_0_0);
    check_eq("rst h4",  {b4.grant,  b4.grant_sel,  b4.grant_valid,  b4.timeout},  8'b0000_00_0_0);
    check_eq("rst h0",  {b0.grant,  b0.grant_sel,  b0.grant_valid,  b0.timeout},  8'b0000_00_0_0);
    sb_q.delete();
    model_reset();
    drive_and_predict(4'b0000, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    b16.req = 4'b0000; b16.done = 1'b0;
    b4.req  = 4'b0000; b4.done  = 1'b0;
    b0.req  = 4'b0000; b0.done  = 1'b0;
    do_reset();

    // Two requesters, owner releases with done, pointer moves past it.
    for (int i = 0; i < 3; i++) cycle(4'b1010, 1'b0);
    cycle(4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) cycle(4'b1010, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // All requesting with done always high: full rotation including wrap 3 -> 0.
    for (int i = 0; i < 12; i++) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b0);

    // Lone requester held with no done: hold-limit preemption and re-grant.
    for (int i = 0; i < 40; i++) cycle(4'b0100, 1'b0);

    // Owner 2 withdraws while requester 0 waits: normal release, then grant 0.
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0);

    // done coinciding with request drop, then a hold-limit edge with done.
    cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b1);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

    // Reset in the middle of owner 3's tenure, then everyone requests.
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 7; i++) cycle(4'b1000, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b0);

    // Long lone request: the unlimited instance must never preempt.
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 300; i++) cycle(4'b0001, 1'b0);

    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
